// File: rtl/data_cache_ctrl.sv
// Direct-mapped window cache controller with DDR writeback/refill bursts.
// Optional hit/miss statistics counters: define DATA_CACHE_STATS_EN.
module data_cache_ctrl #(
  parameter int DATA_CACHE_DEPTH = 16,
  parameter int ADDR_WIDTH_MEM   = 16,
  parameter int DDR_ADDR_WIDTH   = 28,
  parameter int IDX_WIDTH        = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  input  logic                      req_write,
  input  logic [ADDR_WIDTH_MEM-1:0] req_addr,
  output logic                      req_ready,
  output logic                      resp_valid,
  output logic                      resp_miss,
  output logic [IDX_WIDTH-1:0]      resp_idx,
  output logic [15:0]               tag_data,
  output logic                      ddr_rd_req,
  output logic [DDR_ADDR_WIDTH-1:0] ddr_rd_addr,
  input  logic                      rd_burst_data_valid,
  input  logic                      rd_burst_finish,
  output logic                      ddr_wr_req,
  output logic [DDR_ADDR_WIDTH-1:0] ddr_wr_addr,
  input  logic                      wr_burst_data_req,
  input  logic                      wr_burst_finish,
  output logic                      cache_we,
  output logic [IDX_WIDTH-1:0]      cache_waddr,
`ifdef DATA_CACHE_STATS_EN
  output logic [15:0]               hit_cnt,
  output logic [15:0]               miss_cnt,
`endif
  output logic [IDX_WIDTH-1:0]      cache_raddr
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_RESP  = 3'd2;
  localparam logic [2:0] S_WB    = 3'd3;
  localparam logic [2:0] S_FILL  = 3'd4;

  localparam int AW1 = ADDR_WIDTH_MEM + 1;
  localparam int CW  = IDX_WIDTH + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_CACHE_DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_CACHE_DEPTH - 1);

  logic [2:0]                r_state;
  logic [ADDR_WIDTH_MEM-1:0] r_addr;
  logic                      r_write;
  logic [15:0]               r_tag;
  logic                      r_valid;
  logic                      r_dirty;
  logic [CW-1:0]             r_cnt;
  logic                      r_miss;
  logic [IDX_WIDTH-1:0]      r_idx;

  logic [AW1-1:0]       w_addr_ext;
  logic [AW1-1:0]       w_tag_ext;
  logic [AW1-1:0]       w_lim;
  logic                 w_hit;
  logic [IDX_WIDTH-1:0] w_idx;

  // Window bound is one bit wider so a tag near the top cannot wrap.
  always_comb begin
    w_addr_ext = {1'b0, r_addr};
    w_tag_ext  = AW1'(r_tag);
    w_lim      = w_tag_ext + AW1'(DATA_CACHE_DEPTH);
    w_hit      = r_valid && (w_addr_ext >= w_tag_ext)
                 && (w_addr_ext < w_lim);
    w_idx      = r_addr[IDX_WIDTH-1:0] - r_tag[IDX_WIDTH-1:0];
  end

  // Strobes decode straight from state so reset clears them at once.
  always_comb begin
    req_ready   = (r_state == S_IDLE);
    resp_valid  = (r_state == S_RESP);
    resp_miss   = r_miss;
    resp_idx    = r_idx;
    tag_data    = r_tag;
    ddr_rd_req  = (r_state == S_FILL);
    ddr_rd_addr = DDR_ADDR_WIDTH'(r_addr) << 3;
    ddr_wr_req  = (r_state == S_WB);
    ddr_wr_addr = DDR_ADDR_WIDTH'(r_tag) << 3;
    cache_we    = (r_state == S_FILL) && rd_burst_data_valid
                  && (r_cnt < CNT_FULL);
    cache_waddr = r_cnt[IDX_WIDTH-1:0];
    cache_raddr = r_cnt[IDX_WIDTH-1:0];
  end

  // Controller FSM, tag/valid/dirty state and burst beat counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_tag   <= '0;
      r_valid <= 1'b0;
      r_dirty <= 1'b0;
      r_cnt   <= '0;
      r_miss  <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_addr  <= req_addr;
            r_write <= req_write;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          r_cnt <= '0;
          if (w_hit) begin
            r_miss  <= 1'b0;
            r_idx   <= w_idx;
            r_state <= S_RESP;
          end else if (r_valid && r_dirty) begin
            r_state <= S_WB;
          end else begin
            r_state <= S_FILL;
          end
        end
        S_WB: begin
          if (wr_burst_finish) begin
            r_cnt   <= '0;
            r_state <= S_FILL;
          end else if (wr_burst_data_req && (r_cnt < CNT_LAST)) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FILL: begin
          if (rd_burst_data_valid && (r_cnt < CNT_FULL))
            r_cnt <= r_cnt + 1'b1;
          if (rd_burst_finish) begin
            r_tag   <= 16'(r_addr);
            r_valid <= 1'b1;
            r_dirty <= r_write;
            r_miss  <= 1'b1;
            r_idx   <= '0;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (r_write)
            r_dirty <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef DATA_CACHE_STATS_EN
  // Saturating hit/miss counters, bumped once per response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (r_state == S_RESP) begin
      if (r_miss) begin
        if (miss_cnt != 16'hFFFF)
          miss_cnt <= miss_cnt + 16'd1;
      end else begin
        if (hit_cnt != 16'hFFFF)
          hit_cnt <= hit_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Randomized self-checking bench for data_cache_ctrl.
// Reference model tracks window base, valid and dirty as plain integers.
module tb_data_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_miss;
  logic [3:0]  resp_idx;
  logic [15:0] tag_data;
  logic        ddr_rd_req;
  logic [27:0] ddr_rd_addr;
  logic        rd_burst_data_valid = 1'b0;
  logic        rd_burst_finish = 1'b0;
  logic        ddr_wr_req;
  logic [27:0] ddr_wr_addr;
  logic        wr_burst_data_req = 1'b0;
  logic        wr_burst_finish = 1'b0;
  logic        cache_we;
  logic [3:0]  cache_waddr;
  logic [3:0]  cache_raddr;
`ifdef DATA_CACHE_STATS_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
`endif

  int checks = 0;
  int failures = 0;

  bit          m_valid;
  bit          m_dirty;
  int          m_tag;

  always #5 clk = ~clk;

  data_cache_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .req_valid           (req_valid),
    .req_write           (req_write),
    .req_addr            (req_addr),
    .req_ready           (req_ready),
    .resp_valid          (resp_valid),
    .resp_miss           (resp_miss),
    .resp_idx            (resp_idx),
    .tag_data            (tag_data),
    .ddr_rd_req          (ddr_rd_req),
    .ddr_rd_addr         (ddr_rd_addr),
    .rd_burst_data_valid (rd_burst_data_valid),
    .rd_burst_finish     (rd_burst_finish),
    .ddr_wr_req          (ddr_wr_req),
    .ddr_wr_addr         (ddr_wr_addr),
    .wr_burst_data_req   (wr_burst_data_req),
    .wr_burst_finish     (wr_burst_finish),
    .cache_we            (cache_we),
    .cache_waddr         (cache_waddr),
`ifdef DATA_CACHE_STATS_EN
    .hit_cnt             (hit_cnt),
    .miss_cnt            (miss_cnt),
`endif
    .cache_raddr         (cache_raddr)
  );

  task automatic model_reset();
    m_valid = 1'b0;
    m_dirty = 1'b0;
    m_tag   = 0;
  endtask

  // One full access; called at a negedge with the DUT idle.
  task automatic access(input int addr, input bit wr,
                        input int nbeats, input bit coincide);
    bit hit;
    int exp_idx;
    hit = m_valid && (addr >= m_tag) && (addr < m_tag + 16);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL acc_ready got=%b exp=1", req_ready);
    end
    req_valid = 1'b1;
    req_addr  = addr[15:0];
    req_write = wr;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = 16'($urandom);
    req_write = 1'($urandom);
    checks++;
    if (resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL acc_early_resp got=%b exp=0", resp_valid);
    end
    @(negedge clk);
    if (hit) begin
      exp_idx = (addr - m_tag) & 15;
      checks++;
      if (resp_valid !== 1'b1 || resp_miss !== 1'b0 ||
          resp_idx !== 4'(exp_idx)) begin
        failures++;
        $display("FAIL hit_resp addr=%h got v=%b m=%b i=%0d exp v=1 m=0 i=%0d",
                 addr, resp_valid, resp_miss, resp_idx, exp_idx);
      end
      if (wr) m_dirty = 1'b1;
    end else begin
      if (m_valid && m_dirty) begin
        checks++;
        if (ddr_wr_req !== 1'b1 || ddr_rd_req !== 1'b0 ||
            ddr_wr_addr !== 28'(m_tag * 8)) begin
          failures++;
          $display("FAIL wb_start got wr=%b rd=%b a=%h exp wr=1 rd=0 a=%h",
                   ddr_wr_req, ddr_rd_req, ddr_wr_addr, m_tag * 8);
        end
        for (int b = 0; b < 16; b++) begin
          checks++;
          if (cache_raddr !== 4'(b)) begin
            failures++;
            $display("FAIL wb_raddr got=%0d exp=%0d", cache_raddr, b);
          end
          wr_burst_data_req = 1'b1;
          @(negedge clk);
          wr_burst_data_req = 1'b0;
          if ($urandom_range(0, 2) == 0) @(negedge clk);
        end
        checks++;
        if (cache_raddr !== 4'd15 || ddr_wr_req !== 1'b1) begin
          failures++;
          $display("FAIL wb_sat got raddr=%0d wr=%b exp raddr=15 wr=1",
                   cache_raddr, ddr_wr_req);
        end
        wr_burst_finish = 1'b1;
        @(negedge clk);
        wr_burst_finish = 1'b0;
      end
      checks++;
      if (ddr_rd_req !== 1'b1 || ddr_wr_req !== 1'b0 ||
          ddr_rd_addr !== 28'(addr * 8)) begin
        failures++;
        $display("FAIL fill_start got rd=%b wr=%b a=%h exp rd=1 wr=0 a=%h",
                 ddr_rd_req, ddr_wr_req, ddr_rd_addr, addr * 8);
      end
      for (int b = 0; b < nbeats; b++) begin
        rd_burst_data_valid = 1'b1;
        rd_burst_finish = coincide && (b == nbeats - 1);
        #1;
        checks++;
        if (cache_we !== (b < 16) ||
            (b < 16 && cache_waddr !== 4'(b))) begin
          failures++;
          $display("FAIL fill_beat b=%0d got we=%b wa=%0d exp we=%b",
                   b, cache_we, cache_waddr, b < 16);
        end
        @(negedge clk);
        rd_burst_data_valid = 1'b0;
        rd_burst_finish = 1'b0;
        if (b != nbeats - 1 && $urandom_range(0, 2) == 0) @(negedge clk);
      end
      if (!coincide) begin
        rd_burst_finish = 1'b1;
        #1;
        checks++;
        if (cache_we !== 1'b0) begin
          failures++;
          $display("FAIL fill_fin_we got=%b exp=0", cache_we);
        end
        @(negedge clk);
        rd_burst_finish = 1'b0;
      end
      checks++;
      if (resp_valid !== 1'b1 || resp_miss !== 1'b1 ||
          resp_idx !== 4'd0 || tag_data !== addr[15:0]) begin
        failures++;
        $display("FAIL miss_resp got v=%b m=%b i=%0d t=%h exp v=1 m=1 i=0 t=%h",
                 resp_valid, resp_miss, resp_idx, tag_data, addr);
      end
      m_tag   = addr;
      m_valid = 1'b1;
      m_dirty = wr;
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL acc_done got rdy=%b v=%b exp rdy=1 v=0",
               req_ready, resp_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || ddr_rd_req !== 1'b0 ||
        ddr_wr_req !== 1'b0 || cache_we !== 1'b0 || tag_data !== 16'h0) begin
      failures++;
      $display("FAIL reset_state got rdy=%b v=%b rd=%b wr=%b we=%b t=%h",
               req_ready, resp_valid, ddr_rd_req, ddr_wr_req,
               cache_we, tag_data);
    end
    @(negedge clk);
  endtask

  task automatic test_first_fill();
    access(16'h0040, 1'b0, 16, 1'b1);
  endtask

  task automatic test_hit();
    access(16'h004F, 1'b0, 16, 1'b0);
    access(16'h0050, 1'b0, 16, 1'b0);
  endtask

  task automatic test_writeback();
    access(16'h0040, 1'b0, 16, 1'b0);
    access(16'h0041, 1'b1, 16, 1'b0);
    access(16'h0100, 1'b0, 16, 1'b1);
  endtask

  task automatic test_bound();
    access(16'hFFF8, 1'b0, 17, 1'b0);
    access(16'hFFFF, 1'b0, 16, 1'b0);
    access(16'h0007, 1'b0, 18, 1'b1);
  endtask

  task automatic test_reset_mid_fill();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 16'h0040;
    req_write = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ddr_rd_req !== 1'b1) begin
      failures++;
      $display("FAIL rstfill_rd got=%b exp=1", ddr_rd_req);
    end
    for (int b = 0; b < 7; b++) begin
      rd_burst_data_valid = 1'b1;
      @(negedge clk);
      rd_burst_data_valid = 1'b0;
    end
    rd_burst_data_valid = 1'b1;
    rst = 1'b0;
    #1;
    checks++;
    if (ddr_rd_req !== 1'b0 || ddr_wr_req !== 1'b0 ||
        cache_we !== 1'b0 || resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rstfill_outs got rd=%b wr=%b we=%b v=%b exp 0",
               ddr_rd_req, ddr_wr_req, cache_we, resp_valid);
    end
    @(negedge clk);
    rd_burst_data_valid = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (tag_data !== 16'h0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL rstfill_tag got t=%h rdy=%b exp t=0 rdy=1",
               tag_data, req_ready);
    end
    @(negedge clk);
    access(16'h0040, 1'b0, 16, 1'b1);
  endtask

`ifdef DATA_CACHE_STATS_EN
  task automatic test_stats();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    access(16'h0040, 1'b0, 16, 1'b1);
    access(16'h0041, 1'b0, 16, 1'b0);
    access(16'h004F, 1'b1, 16, 1'b0);
    access(16'h0047, 1'b0, 16, 1'b0);
    checks++;
    if (hit_cnt !== 16'd3 || miss_cnt !== 16'd1) begin
      failures++;
      $display("FAIL stats got h=%0d m=%0d exp h=3 m=1", hit_cnt, miss_cnt);
    end
  endtask
`endif

  task automatic test_random();
    int addr;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) != 0)
        addr = (m_tag + $urandom_range(0, 19)) & 16'hFFFF;
      else
        addr = $urandom_range(0, 65535);
      access(addr, 1'($urandom), $urandom_range(16, 18),
             1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_first_fill();
    test_hit();
    test_writeback();
    test_bound();
    test_reset_mid_fill();
`ifdef DATA_CACHE_STATS_EN
    test_stats();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
